// File: rtl/snake_pkg.sv
// Shared encodings and helpers for the snake game control path.
// Direction/state codes, grid size, reversal test.
package snake_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_OVER  = 2'b11
  } game_st_e;

  localparam int GRID_W = 40;
  localparam int GRID_H = 30;

  // Opposite directions differ only in bit 1.
  function automatic logic is_reverse(
    input logic [1:0] a,
    input logic [1:0] b
  );
    return a == (b ^ 2'b10);
  endfunction

endpackage

// File: rtl/snake_move_ctrl_if.sv
// Button/status bundle between the input logic and snake_move_ctrl.
// master drives presses and collision; slave returns tick/dir/state/level.
interface snake_move_ctrl_if;

  logic       btn_up;
  logic       btn_right;
  logic       btn_down;
  logic       btn_left;
  logic       start_btn;
  logic       pause_btn;
  logic       collision;
  logic       tick;
  logic [1:0] dir;
  logic [1:0] game_state;
  logic [1:0] queue_level;

  modport master (
    output btn_up, btn_right, btn_down, btn_left,
    output start_btn, pause_btn, collision,
    input  tick, dir, game_state, queue_level
  );

  modport slave (
    input  btn_up, btn_right, btn_down, btn_left,
    input  start_btn, pause_btn, collision,
    output tick, dir, game_state, queue_level
  );

endinterface

// File: rtl/snake_dir_queue.sv
// Two-entry direction FIFO; pop is applied before push in one cycle.
// Ports: push/pop/flush, data in, current dir, head, filter ref, level.
module snake_dir_queue (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic       i_flush,
  input  logic [1:0] i_data,
  input  logic [1:0] i_cur_dir,
  output logic [1:0] o_head,
  output logic [1:0] o_ref,
  output logic [1:0] o_level
);

  logic [1:0] r_q0;
  logic [1:0] r_q1;
  logic [1:0] r_level;

  assign o_head  = r_q0;
  assign o_level = r_level;

  // New requests are compared with the newest queued move,
  // falling back to the live direction when nothing is queued.
  always_comb begin
    o_ref = i_cur_dir;
    if (r_level == 2'd1) o_ref = r_q0;
    if (r_level == 2'd2) o_ref = r_q1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q0    <= 2'b00;
      r_q1    <= 2'b00;
      r_level <= 2'd0;
    end else if (i_flush) begin
      r_level <= 2'd0;
    end else begin
      unique case (r_level)
        2'd0: begin
          if (i_push) begin
            r_q0    <= i_data;
            r_level <= 2'd1;
          end
        end
        2'd1: begin
          if (i_pop && i_push) begin
            r_q0 <= i_data;
          end else if (i_pop) begin
            r_level <= 2'd0;
          end else if (i_push) begin
            r_q1    <= i_data;
            r_level <= 2'd2;
          end
        end
        2'd2: begin
          // Full: a push only fits when the head leaves this cycle.
          if (i_pop) begin
            r_q0 <= r_q1;
            if (i_push) r_q1 <= i_data;
            else r_level <= 2'd1;
          end
        end
        default: r_level <= 2'd0;
      endcase
    end
  end

endmodule

// File: rtl/snake_move_ctrl.sv
// Snake head sequencer: tick divider, run/pause/over FSM, move queue.
// Ports: clk, reset (async high), bus (slave side of snake_move_ctrl_if).
module snake_move_ctrl
  import snake_pkg::*;
#(
  parameter int         TICK_DIV  = 6250000,
  parameter int         TICK_BITS = 23,
  parameter logic [1:0] INIT_DIR  = 2'b01
) (
  input logic               clk,
  input logic               reset,
  snake_move_ctrl_if.slave  bus
);

  localparam logic [TICK_BITS-1:0] LAST = TICK_BITS'(TICK_DIV - 1);

  game_st_e             r_state;
  logic [TICK_BITS-1:0] r_cnt;
  logic                 r_tick;
  logic [1:0]           r_dir;

  logic [1:0] w_req;
  logic       w_req_vld;
  logic [1:0] w_head;
  logic [1:0] w_ref;
  logic [1:0] w_level;
  logic       w_run;
  logic       w_tick_now;
  logic       w_accept;
  logic       w_flush;

  always_comb begin
    w_req     = DIR_UP;
    w_req_vld = 1'b1;
    priority case (1'b1)
      bus.btn_up:    w_req = DIR_UP;
      bus.btn_right: w_req = DIR_RIGHT;
      bus.btn_down:  w_req = DIR_DOWN;
      bus.btn_left:  w_req = DIR_LEFT;
      default:       w_req_vld = 1'b0;
    endcase
  end

  assign w_run = (r_state == ST_RUN);

  // Cycle whose closing edge raises tick and pops the queue.
  assign w_tick_now = w_run && !bus.collision &&
                      !bus.pause_btn && (r_cnt == LAST);

  assign w_accept = w_run && w_req_vld && !bus.collision &&
                    (w_req != w_ref) && !is_reverse(w_req, w_ref);

  assign w_flush = (w_run && bus.collision) ||
                   (r_state == ST_OVER && bus.start_btn);

  snake_dir_queue u_queue (
    .i_clk     (clk),
    .i_rst     (reset),
    .i_push    (w_accept),
    .i_pop     (w_tick_now),
    .i_flush   (w_flush),
    .i_data    (w_req),
    .i_cur_dir (r_dir),
    .o_head    (w_head),
    .o_ref     (w_ref),
    .o_level   (w_level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_tick  <= 1'b0;
      r_dir   <= INIT_DIR;
    end else begin
      r_tick <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (bus.start_btn) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
          end
        end
        ST_RUN: begin
          if (bus.collision) begin
            r_state <= ST_OVER;
          end else if (bus.pause_btn) begin
            r_state <= ST_PAUSE;
          end else if (r_cnt == LAST) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
            if (w_level != 2'd0) r_dir <= w_head;
          end else begin
            r_cnt <= r_cnt + TICK_BITS'(1);
          end
        end
        ST_PAUSE: begin
          if (bus.pause_btn) r_state <= ST_RUN;
        end
        ST_OVER: begin
          if (bus.start_btn) begin
            r_state <= ST_IDLE;
            r_dir   <= INIT_DIR;
            r_cnt   <= '0;
          end
        end
      endcase
    end
  end

  assign bus.tick        = r_tick;
  assign bus.dir         = r_dir;
  assign bus.game_state  = r_state;
  assign bus.queue_level = w_level;

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Directed bench for snake_move_ctrl with TICK_DIV=4.
// Snapshot packs {game_state, tick, dir, queue_level} into 7 bits.
module tb_snake_move_ctrl;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   compared   = 0;
  int   mismatched = 0;
  logic [6:0] snap;

  snake_move_ctrl_if bus ();

  snake_move_ctrl #(
    .TICK_DIV  (4),
    .TICK_BITS (3),
    .INIT_DIR  (2'b01)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign snap = {bus.game_state, bus.tick, bus.dir, bus.queue_level};

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_inputs();
    bus.btn_up    = 1'b0;
    bus.btn_right = 1'b0;
    bus.btn_down  = 1'b0;
    bus.btn_left  = 1'b0;
    bus.start_btn = 1'b0;
    bus.pause_btn = 1'b0;
    bus.collision = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    step(2);
    compared++;
    if (snap !== 7'b00_0_01_00) begin
      mismatched++;
      $display("FAIL reset_state got=%b want=%b", snap, 7'b00_0_01_00);
    end
    reset = 1'b0;
    step(1);
    // Presses and pause are ignored in IDLE.
    bus.btn_up    = 1'b1;
    bus.pause_btn = 1'b1;
    step(1);
    clear_inputs();
    compared++;
    if (snap !== 7'b00_0_01_00) begin
      mismatched++;
      $display("FAIL idle_ignore got=%b want=%b", snap, 7'b00_0_01_00);
    end
  endtask

  task automatic test_start();
    bus.start_btn = 1'b1;
    step(1);
    bus.start_btn = 1'b0;
    compared++;
    if (snap !== 7'b01_0_01_00) begin
      mismatched++;
      $display("FAIL start_run got=%b want=%b", snap, 7'b01_0_01_00);
    end
    for (int p = 0; p < 2; p++) begin
      for (int i = 1; i <= 3; i++) begin
        step(1);
        compared++;
        if (bus.tick !== 1'b0) begin
          mismatched++;
          $display("FAIL tick_early p=%0d c=%0d got=%b want=0",
                   p, i, bus.tick);
        end
      end
      step(1);
      compared++;
      if (snap !== 7'b01_1_01_00) begin
        mismatched++;
        $display("FAIL tick_period p=%0d got=%b want=%b",
                 p, snap, 7'b01_1_01_00);
      end
    end
  endtask

  task automatic test_reject();
    bus.btn_left = 1'b1;
    step(1);
    bus.btn_left  = 1'b0;
    bus.btn_right = 1'b1;
    step(1);
    bus.btn_right = 1'b0;
    compared++;
    if (bus.queue_level !== 2'd0) begin
      mismatched++;
      $display("FAIL reject_level got=%0d want=0", bus.queue_level);
    end
    step(2);
    compared++;
    if (snap !== 7'b01_1_01_00) begin
      mismatched++;
      $display("FAIL reject_tick got=%b want=%b", snap, 7'b01_1_01_00);
    end
  endtask

  task automatic test_queue();
    bus.btn_up = 1'b1;
    step(1);
    bus.btn_up   = 1'b0;
    bus.btn_left = 1'b1;
    step(1);
    bus.btn_left = 1'b0;
    compared++;
    if (bus.queue_level !== 2'd2) begin
      mismatched++;
      $display("FAIL queue_fill got=%0d want=2", bus.queue_level);
    end
    step(2);
    compared++;
    if (snap !== 7'b01_1_00_01) begin
      mismatched++;
      $display("FAIL queue_pop1 got=%b want=%b", snap, 7'b01_1_00_01);
    end
    step(4);
    compared++;
    if (snap !== 7'b01_1_11_00) begin
      mismatched++;
      $display("FAIL queue_pop2 got=%b want=%b", snap, 7'b01_1_11_00);
    end
  endtask

  task automatic test_pop_push();
    bus.btn_up = 1'b1;
    step(1);
    bus.btn_up   = 1'b0;
    bus.btn_left = 1'b1;
    step(1);
    bus.btn_left = 1'b0;
    // Press while full with no pop pending: dropped.
    bus.btn_down = 1'b1;
    step(1);
    compared++;
    if (snap !== 7'b01_0_11_10) begin
      mismatched++;
      $display("FAIL full_drop got=%b want=%b", snap, 7'b01_0_11_10);
    end
    // Press on the tick edge: pop then push.
    step(1);
    bus.btn_down = 1'b0;
    compared++;
    if (snap !== 7'b01_1_00_10) begin
      mismatched++;
      $display("FAIL pop_push got=%b want=%b", snap, 7'b01_1_00_10);
    end
    step(4);
    compared++;
    if (snap !== 7'b01_1_11_01) begin
      mismatched++;
      $display("FAIL pp_entry1 got=%b want=%b", snap, 7'b01_1_11_01);
    end
    step(4);
    compared++;
    if (snap !== 7'b01_1_10_00) begin
      mismatched++;
      $display("FAIL pp_entry2 got=%b want=%b", snap, 7'b01_1_10_00);
    end
  endtask

  task automatic test_pause();
    step(2);
    bus.pause_btn = 1'b1;
    step(1);
    bus.pause_btn = 1'b0;
    compared++;
    if ({bus.game_state, bus.tick} !== 3'b10_0) begin
      mismatched++;
      $display("FAIL pause_enter got=%b want=%b",
               {bus.game_state, bus.tick}, 3'b10_0);
    end
    for (int i = 0; i < 10; i++) begin
      if (i == 4) bus.start_btn = 1'b1;
      if (i == 6) bus.collision = 1'b1;
      step(1);
      clear_inputs();
      compared++;
      if ({bus.game_state, bus.tick} !== 3'b10_0) begin
        mismatched++;
        $display("FAIL pause_hold c=%0d got=%b want=%b",
                 i, {bus.game_state, bus.tick}, 3'b10_0);
      end
    end
    bus.pause_btn = 1'b1;
    step(1);
    bus.pause_btn = 1'b0;
    compared++;
    if ({bus.game_state, bus.tick} !== 3'b01_0) begin
      mismatched++;
      $display("FAIL resume got=%b want=%b",
               {bus.game_state, bus.tick}, 3'b01_0);
    end
    step(1);
    compared++;
    if (bus.tick !== 1'b0) begin
      mismatched++;
      $display("FAIL resume_early got=%b want=0", bus.tick);
    end
    step(1);
    compared++;
    if (bus.tick !== 1'b1) begin
      mismatched++;
      $display("FAIL resume_tick got=%b want=1", bus.tick);
    end
  endtask

  task automatic test_collision();
    bus.btn_left = 1'b1;
    step(1);
    bus.btn_left = 1'b0;
    compared++;
    if (bus.queue_level !== 2'd1) begin
      mismatched++;
      $display("FAIL coll_prep got=%0d want=1", bus.queue_level);
    end
    bus.collision = 1'b1;
    step(1);
    bus.collision = 1'b0;
    compared++;
    if (snap !== 7'b11_0_10_00) begin
      mismatched++;
      $display("FAIL coll_over got=%b want=%b", snap, 7'b11_0_10_00);
    end
    for (int i = 0; i < 5; i++) begin
      step(1);
      compared++;
      if (snap !== 7'b11_0_10_00) begin
        mismatched++;
        $display("FAIL over_hold c=%0d got=%b want=%b",
                 i, snap, 7'b11_0_10_00);
      end
    end
    bus.start_btn = 1'b1;
    step(1);
    bus.start_btn = 1'b0;
    compared++;
    if (snap !== 7'b00_0_01_00) begin
      mismatched++;
      $display("FAIL over_idle got=%b want=%b", snap, 7'b00_0_01_00);
    end
  endtask

  task automatic test_reset_mid();
    bus.start_btn = 1'b1;
    step(1);
    bus.start_btn = 1'b0;
    bus.btn_up    = 1'b1;
    step(1);
    bus.btn_up = 1'b0;
    step(3);
    compared++;
    if (snap !== 7'b01_1_00_00) begin
      mismatched++;
      $display("FAIL mid_prep got=%b want=%b", snap, 7'b01_1_00_00);
    end
    bus.btn_right = 1'b1;
    step(1);
    bus.btn_right = 1'b0;
    step(1);
    #2;
    reset = 1'b1;
    #1;
    compared++;
    if (snap !== 7'b00_0_01_00) begin
      mismatched++;
      $display("FAIL reset_async got=%b want=%b", snap, 7'b00_0_01_00);
    end
    step(1);
    reset = 1'b0;
    step(1);
    compared++;
    if (snap !== 7'b00_0_01_00) begin
      mismatched++;
      $display("FAIL reset_after got=%b want=%b", snap, 7'b00_0_01_00);
    end
  endtask

  task automatic test_priority();
    bus.start_btn = 1'b1;
    step(1);
    bus.start_btn = 1'b0;
    // Up and down together: only up is taken.
    bus.btn_up   = 1'b1;
    bus.btn_down = 1'b1;
    step(1);
    clear_inputs();
    compared++;
    if (bus.queue_level !== 2'd1) begin
      mismatched++;
      $display("FAIL prio_level got=%0d want=1", bus.queue_level);
    end
    step(3);
    compared++;
    if (snap !== 7'b01_1_00_00) begin
      mismatched++;
      $display("FAIL prio_dir got=%b want=%b", snap, 7'b01_1_00_00);
    end
    bus.collision = 1'b1;
    bus.pause_btn = 1'b1;
    step(1);
    clear_inputs();
    compared++;
    if ({bus.game_state, bus.tick} !== 3'b11_0) begin
      mismatched++;
      $display("FAIL coll_vs_pause got=%b want=%b",
               {bus.game_state, bus.tick}, 3'b11_0);
    end
    bus.start_btn = 1'b1;
    step(1);
    bus.start_btn = 1'b0;
    compared++;
    if (bus.game_state !== 2'b00) begin
      mismatched++;
      $display("FAIL final_idle got=%b want=00", bus.game_state);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_reject();
    test_queue();
    test_pop_push();
    test_pause();
    test_collision();
    test_reset_mid();
    test_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
